// File: rtl/sync_byte_memory.sv
// Byte-addressed single-port memory with word-wide little-endian access.
// Zero-fills itself after reset and on request, and holds each read response until it is consumed.
//
// state | meaning
// INIT  | zero-filling one byte per cycle; no requests accepted
// IDLE  | accepting reads, writes or a clear request
// RESP  | read data held on o_data_out until i_rready
module sync_byte_memory #(
    parameter int ADDRESS_SIZE = 8,
    parameter int BYTE_SIZE    = 8,
    parameter int WORD_SIZE    = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_req,
    input  logic                            i_we,
    input  logic [WORD_SIZE/BYTE_SIZE-1:0]  i_be,
    input  logic [ADDRESS_SIZE-1:0]         i_address,
    input  logic [WORD_SIZE-1:0]            i_data_in,
    input  logic                            i_rready,
    input  logic                            i_clr,
    output logic                            o_ready,
    output logic                            o_valid,
    output logic [WORD_SIZE-1:0]            o_data_out,
    output logic                            o_init_done
);

    localparam int NB    = WORD_SIZE / BYTE_SIZE;
    localparam int DEPTH = 2 ** ADDRESS_SIZE;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t                     state, state_nxt;
    logic [ADDRESS_SIZE-1:0]    fill_cnt, fill_cnt_nxt;
    logic                       init_done, init_done_nxt;
    logic [WORD_SIZE-1:0]       data_out, data_nxt;
    logic                       fill_write;
    logic                       accept_wr;

    logic [BYTE_SIZE-1:0]       mem [DEPTH];
    logic [ADDRESS_SIZE-1:0]    lane_addr [NB];
    logic [WORD_SIZE-1:0]       rd_word;

    // Lane addresses wrap naturally through the ADDRESS_SIZE-bit adder.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            lane_addr[k] = i_address + ADDRESS_SIZE'(k);
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NB; k++) begin
            rd_word[k*BYTE_SIZE +: BYTE_SIZE] = mem[lane_addr[k]];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_INIT;
            fill_cnt  <= '0;
            init_done <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_cnt_nxt;
            init_done <= init_done_nxt;
            data_out  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fill_cnt_nxt  = fill_cnt;
        init_done_nxt = init_done;
        data_nxt      = data_out;
        fill_write    = 1'b0;
        accept_wr     = 1'b0;
        case (state)
            ST_INIT: begin
                fill_write   = 1'b1;
                fill_cnt_nxt = fill_cnt + 1'b1;
                if (fill_cnt == '1) begin
                    state_nxt     = ST_IDLE;
                    init_done_nxt = 1'b1;
                end
            end
            ST_IDLE: begin
                // A request always wins over a simultaneous clear.
                if (i_req) begin
                    if (i_we) begin
                        accept_wr = 1'b1;
                    end else begin
                        data_nxt  = rd_word;
                        state_nxt = ST_RESP;
                    end
                end else if (i_clr) begin
                    fill_cnt_nxt = '0;
                    state_nxt    = ST_INIT;
                end
            end
            ST_RESP: begin
                if (i_rready) begin
                    data_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Storage has no reset; the INIT fill is what clears it.
    always_ff @(posedge i_clk) begin
        if (fill_write) begin
            mem[fill_cnt] <= '0;
        end else if (accept_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (i_be[k]) begin
                    mem[lane_addr[k]] <= i_data_in[k*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    assign o_ready     = (state == ST_IDLE);
    assign o_valid     = (state == ST_RESP);
    assign o_data_out  = data_out;
    assign o_init_done = init_done;

endmodule

// File: doc/sync_byte_memory.md
SYNC_BYTE_MEMORY -- requirements
Module: sync_byte_memory

Interface
REQ-001 Parameter ADDRESS_SIZE, default 8: byte-address width; depth = 2**ADDRESS_SIZE bytes.
REQ-002 Parameter BYTE_SIZE, default 8: bits per storage location.
REQ-003 Parameter WORD_SIZE, default 32: access width; an integer multiple of BYTE_SIZE; NB = WORD_SIZE/BYTE_SIZE lanes.
REQ-004 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-006 i_req  in  1  access request; sampled only when o_ready=1.
REQ-007 i_we  in  1  1=write, 0=read; qualified by i_req.
REQ-008 i_be  in  NB  write byte-lane enables; lane k = i_data_in[(k+1)*BYTE_SIZE-1 : k*BYTE_SIZE].
REQ-009 i_address  in  ADDRESS_SIZE  byte address of lane 0.
REQ-010 i_data_in  in  WORD_SIZE  write data.
REQ-011 i_rready  in  1  consumer accepts read data.
REQ-012 i_clr  in  1  request a full zero-fill; sampled in IDLE only.
REQ-013 o_ready  out  1  block accepts a request this cycle.
REQ-014 o_valid  out  1  o_data_out holds read data.
REQ-015 o_data_out  out  WORD_SIZE  read data; all zeros whenever o_valid=0.
REQ-016 o_init_done  out  1  high once the first zero-fill after reset has completed.

Function
REQ-017 The FSM SHALL have three states: INIT, IDLE, RESP.
REQ-018 In INIT, a fill counter SHALL write zero to byte address = counter each cycle, from 0 to 2**ADDRESS_SIZE-1.
- After the last address, the FSM SHALL go to IDLE and set o_init_done=1.
- o_init_done SHALL stay set until the next reset.
REQ-019 o_ready SHALL be 1 only in IDLE; requests are never accepted in INIT or RESP.
REQ-020 Write acceptance (IDLE, i_req=1, i_we=1): at that edge, for each lane k with i_be[k]=1, byte (i_address+k) mod 2**ADDRESS_SIZE SHALL take lane k.
- Disabled lanes SHALL keep their contents.
- The FSM SHALL stay in IDLE, giving back-to-back writes one per cycle.
- A write SHALL produce no response.
REQ-021 Read acceptance (IDLE, i_req=1, i_we=0): at that edge, o_data_out SHALL be registered as {byte[a+NB-1], ..., byte[a+1], byte[a]} (little-endian, all indices mod depth), the FSM SHALL go to RESP, and o_valid=1 from the next cycle.
- Read latency SHALL be 1 cycle.
- i_be SHALL be ignored on reads.
REQ-022 In RESP, o_valid and o_data_out SHALL hold stable until a cycle with i_rready=1.
- At that edge the FSM SHALL go to IDLE, o_valid SHALL go to 0 and o_data_out to 0.
REQ-023 Address wrap: an access with i_address > depth-NB SHALL wrap byte lanes to address 0 upward; no error.
REQ-024 i_clr=1 in IDLE with i_req=0 SHALL reset the fill counter to 0 and enter INIT.
- If i_clr=1 and i_req=1 in the same cycle, the request SHALL be served and i_clr ignored.
- i_clr SHALL be ignored in INIT and RESP.
REQ-025 A write and a later read of the same bytes SHALL return the written data; there is no read-during-write case, because one access is accepted per cycle.

Reset
REQ-026 On i_rst_n=0, immediately and regardless of clock:
- state=INIT, fill counter=0;
- o_ready=0, o_valid=0, o_data_out=0, o_init_done=0.
REQ-027 Memory contents SHALL NOT be reset asynchronously; they are zeroed by the INIT fill after reset deasserts.
REQ-028 Reset asserted mid-fill, mid-write or in RESP SHALL abort the operation; any pending read response is discarded.

Verification
REQ-029 Release reset, count cycles -> o_ready=0 for exactly 256 cycles (default params), then o_ready=1 and o_init_done=1; a read of 0x40 returns 0x00000000.
REQ-030 Write 0xDEADBEEF to 0x10 with i_be=4'b1111, then read 0x10 -> o_valid one cycle after acceptance, o_data_out=0xDEADBEEF; read 0x11 -> 0x00DEADBE.
REQ-031 Over 0x11223344 at 0x20, write 0xAABBCCDD with i_be=4'b0101, read 0x20 -> 0x11BB33DD.
REQ-032 Write 0x04030201 to 0xFE, read 0xFE -> 0x04030201; read 0x00 -> 0x????0403 with bytes 0x03 at address 0x00 and 0x04 at address 0x01 (wrap), upper bytes unchanged.
REQ-033 Read with i_rready=0 for 5 cycles -> o_valid=1, o_data_out stable, o_ready=0 throughout; i_req pulses in RESP are ignored; raising i_rready gives o_valid=0 and o_ready=1 next cycle.
REQ-034 Assert i_clr after writing nonzero data -> 256 cycles with o_ready=0 and o_init_done=1; then all reads return 0. Asserting i_rst_n=0 mid-fill drops all outputs to 0 at once.
